// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the dual-PSRAM controller.
// Both QSPI chips receive identical command/address nibbles.
package mem_ctrl_pkg;

    typedef enum logic [3:0] {
        stateInit_1,
        stateInit_2,
        stateEnableQPI,
        stateIdle,
        stateCmd,
        stateAddr,
        stateWait,
        stateWriteData,
        stateReadData,
        stateDeselect
    } state_t;

    localparam logic [7:0] enableQPIMode  = 8'h35;
    localparam logic [7:0] cmdQuadWrite   = 8'h38;
    localparam logic [7:0] cmdQuadRead    = 8'hEB;
    localparam logic [3:0] readWaitCycles = 4'd6;
    localparam logic [3:0] deselectCycles = 4'd2;

endpackage

// File: rtl/mem_ctrl_psram_io_drive.sv
// Per-chip 4-bit tristate driver and input sampler.
// Each SIO line has its own output enable.
module psram_io_drive (
    input  logic [3:0] oe,
    input  logic [3:0] dout,
    output logic [3:0] din,
    inout  wire        io0,
    inout  wire        io1,
    inout  wire        io2,
    inout  wire        io3
);

    assign io0 = oe[0] ? dout[0] : 1'bz;
    assign io1 = oe[1] ? dout[1] : 1'bz;
    assign io2 = oe[2] ? dout[2] : 1'bz;
    assign io3 = oe[3] ? dout[3] : 1'bz;

    assign din = {io3, io2, io1, io0};

endmodule

// File: rtl/mem_ctrl.sv
// Dual APS6404-class PSRAM controller: U7 = low nibble, U9 = high nibble.
// Init to QPI mode, then single-byte reads and 1..15-byte burst writes.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned initDelayInClkCyles = 7500
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         CE,
    input  logic         write,
    input  logic [6:0]   bank,
    input  logic [15:0]  addrBus,
    input  logic [3:0]   numberOfBytesToWrite,
    input  logic [119:0] dataToWrite,
    output logic [7:0]   dataRead,
    output logic         busy,
    inout  wire          io_psram_data0,
    inout  wire          io_psram_data1,
    inout  wire          io_psram_data2,
    inout  wire          io_psram_data3,
    inout  wire          io_psram_data4,
    inout  wire          io_psram_data5,
    inout  wire          io_psram_data6,
    inout  wire          io_psram_data7,
    output logic         o_psram_cs,
    output logic         o_psram_sclk
);

    state_t         state_q, state_d;
    logic [31:0]    delay_cnt_q, delay_cnt_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [23:0]    shift_q, shift_d;
    logic [23:0]    addr_q, addr_d;
    logic [119:0]   data_q, data_d;
    logic [3:0]     count_q, count_d;
    logic           write_q, write_d;
    logic           cs_q, cs_d;
    logic [7:0]     oe_q, oe_d;
    logic [7:0]     dout_q, dout_d;
    logic           busy_q, busy_d;
    logic [7:0]     data_read_q, data_read_d;
    logic [3:0]     din_lo, din_hi;

    psram_io_drive u7 (
        .oe   (oe_q[3:0]),
        .dout (dout_q[3:0]),
        .din  (din_lo),
        .io0  (io_psram_data0),
        .io1  (io_psram_data1),
        .io2  (io_psram_data2),
        .io3  (io_psram_data3)
    );

    psram_io_drive u9 (
        .oe   (oe_q[7:4]),
        .dout (dout_q[7:4]),
        .din  (din_hi),
        .io0  (io_psram_data4),
        .io1  (io_psram_data5),
        .io2  (io_psram_data6),
        .io3  (io_psram_data7)
    );

    always_comb begin
        state_d     = state_q;
        delay_cnt_d = delay_cnt_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        addr_d      = addr_q;
        data_d      = data_q;
        count_d     = count_q;
        write_d     = write_q;
        cs_d        = cs_q;
        oe_d        = oe_q;
        dout_d      = dout_q;
        busy_d      = busy_q;
        data_read_d = data_read_q;
        unique case (state_q)
            stateInit_1: begin
                if (delay_cnt_q <= 32'd1) begin
                    delay_cnt_d = '0;
                    state_d     = stateInit_2;
                end else begin
                    delay_cnt_d = delay_cnt_q - 32'd1;
                end
            end
            stateInit_2: begin
                shift_d = {enableQPIMode, 16'h0000};
                cnt_d   = 4'd8;
                state_d = stateEnableQPI;
            end
            stateEnableQPI: begin
                // Still in SPI mode: SO lines float, WP#/HOLD# held high.
                cs_d    = 1'b0;
                oe_d    = 8'b1101_1101;
                dout_d  = {3'b110, shift_q[23], 3'b110, shift_q[23]};
                shift_d = {shift_q[22:0], 1'b0};
                cnt_d   = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = stateDeselect;
                    cnt_d   = deselectCycles + 4'd1;
                end
            end
            stateIdle: begin
                if (CE && !(write && numberOfBytesToWrite == 4'd0)) begin
                    write_d = write;
                    count_d = numberOfBytesToWrite;
                    addr_d  = {1'b0, bank, addrBus};
                    data_d  = dataToWrite;
                    shift_d = {(write ? cmdQuadWrite : cmdQuadRead), 16'h0000};
                    cnt_d   = 4'd2;
                    busy_d  = 1'b1;
                    state_d = stateCmd;
                end
            end
            stateCmd, stateAddr: begin
                cs_d    = 1'b0;
                oe_d    = 8'hFF;
                dout_d  = {shift_q[23:20], shift_q[23:20]};
                shift_d = {shift_q[19:0], 4'h0};
                cnt_d   = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    if (state_q == stateCmd) begin
                        shift_d = addr_q;
                        cnt_d   = 4'd6;
                        state_d = stateAddr;
                    end else if (write_q) begin
                        cnt_d   = count_q;
                        state_d = stateWriteData;
                    end else begin
                        // Extra cycle is the read-data cycle itself.
                        cnt_d   = readWaitCycles + 4'd1;
                        state_d = stateWait;
                    end
                end
            end
            stateWriteData: begin
                cs_d   = 1'b0;
                oe_d   = 8'hFF;
                dout_d = data_q[7:0];
                data_d = {8'h00, data_q[119:8]};
                cnt_d  = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = stateDeselect;
                    cnt_d   = deselectCycles + 4'd1;
                end
            end
            stateWait: begin
                cs_d  = 1'b0;
                oe_d  = 8'h00;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = stateReadData;
                end
            end
            stateReadData: begin
                data_read_d = {din_hi, din_lo};
                cs_d        = 1'b1;
                oe_d        = 8'h00;
                cnt_d       = deselectCycles;
                state_d     = stateDeselect;
            end
            stateDeselect: begin
                cs_d = 1'b1;
                oe_d = 8'h00;
                if (cnt_q <= 4'd1) begin
                    busy_d  = 1'b0;
                    state_d = stateIdle;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = stateInit_1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= stateInit_1;
            delay_cnt_q <= 32'(initDelayInClkCyles);
            cnt_q       <= '0;
            shift_q     <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            count_q     <= '0;
            write_q     <= 1'b0;
            cs_q        <= 1'b1;
            oe_q        <= '0;
            dout_q      <= '0;
            busy_q      <= 1'b1;
            data_read_q <= '0;
        end else begin
            state_q     <= state_d;
            delay_cnt_q <= delay_cnt_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            count_q     <= count_d;
            write_q     <= write_d;
            cs_q        <= cs_d;
            oe_q        <= oe_d;
            dout_q      <= dout_d;
            busy_q      <= busy_d;
            data_read_q <= data_read_d;
        end
    end

    // Chip samples mid-bit on the rising edge of the inverted clock.
    assign o_psram_sclk = ~cs_q & ~clk;
    assign o_psram_cs   = cs_q;
    assign busy         = busy_q;
    assign dataRead     = data_read_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: expected bus nibbles per cs-low cycle
// and expected dataRead at each busy fall are queued by the stimulus.
module tb_mem_ctrl;

    localparam int INIT = 7500;

    typedef struct {
        logic [7:0] v;
        logic       chk;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         CE = 1'b0;
    logic         write = 1'b0;
    logic [6:0]   bank = '0;
    logic [15:0]  addrBus = '0;
    logic [3:0]   nb = '0;
    logic [119:0] dtw = '0;
    logic [7:0]   data_read;
    logic         busy;
    logic         cs;
    logic         sclk;

    wire io0, io1, io2, io3, io4, io5, io6, io7;
    pullup (io0);
    pullup (io1);
    pullup (io2);
    pullup (io3);
    pullup (io4);
    pullup (io5);
    pullup (io6);
    pullup (io7);

    logic       mdl_oe = 1'b0;
    logic       mdl_read = 1'b0;
    logic [7:0] mdl_val = '0;
    int         cyc = 0;

    assign io0 = mdl_oe ? mdl_val[0] : 1'bz;
    assign io1 = mdl_oe ? mdl_val[1] : 1'bz;
    assign io2 = mdl_oe ? mdl_val[2] : 1'bz;
    assign io3 = mdl_oe ? mdl_val[3] : 1'bz;
    assign io4 = mdl_oe ? mdl_val[4] : 1'bz;
    assign io5 = mdl_oe ? mdl_val[5] : 1'bz;
    assign io6 = mdl_oe ? mdl_val[6] : 1'bz;
    assign io7 = mdl_oe ? mdl_val[7] : 1'bz;

    wire [7:0] bus = {io7, io6, io5, io4, io3, io2, io1, io0};

    mem_ctrl #(.initDelayInClkCyles(INIT)) dut (
        .clk                  (clk),
        .reset                (reset),
        .CE                   (CE),
        .write                (write),
        .bank                 (bank),
        .addrBus              (addrBus),
        .numberOfBytesToWrite (nb),
        .dataToWrite          (dtw),
        .dataRead             (data_read),
        .busy                 (busy),
        .io_psram_data0       (io0),
        .io_psram_data1       (io1),
        .io_psram_data2       (io2),
        .io_psram_data3       (io3),
        .io_psram_data4       (io4),
        .io_psram_data5       (io5),
        .io_psram_data6       (io6),
        .io_psram_data7       (io7),
        .o_psram_cs           (cs),
        .o_psram_sclk         (sclk)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    exp_t       bus_q[$];
    logic [7:0] rd_q[$];
    logic [7:0] vec[$];
    exp_t       mon_e;
    logic       prev_busy = 1'b0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic push_vec();
        exp_t e;
        foreach (vec[i]) begin
            e.v   = vec[i];
            e.chk = 1'b1;
            bus_q.push_back(e);
        end
    endtask

    task automatic push_wait_data();
        exp_t e;
        e.v   = 8'hFF;
        e.chk = 1'b1;
        repeat (6) bus_q.push_back(e);
        e.v   = 8'h00;
        e.chk = 1'b0;
        bus_q.push_back(e);
    endtask

    // Model: drive the read byte during the 15th cs-low cycle of a read frame.
    always @(negedge clk) begin
        if (cs) cyc = 0;
        else cyc++;
        mdl_oe = !cs && cyc == 15 && mdl_read;
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (!cs) begin
                if (bus_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL bus_extra act=%0h exp=none", bus);
                end else begin
                    mon_e = bus_q.pop_front();
                    if (mon_e.chk) check("bus", bus, mon_e.v);
                end
            end
            if (prev_busy && !busy) begin
                check("bus_left", bus_q.size(), 0);
                if (rd_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rd_extra act=%0h exp=none", data_read);
                end else begin
                    check("dataRead", data_read, rd_q.pop_front());
                end
            end
        end
        prev_busy = busy;
    end

    task automatic push_init();
        vec = '{8'hEE, 8'hEE, 8'hFF, 8'hFF, 8'hEE, 8'hFF, 8'hEE, 8'hFF};
        push_vec();
        rd_q.push_back(8'h00);
    endtask

    task automatic init_wait(input longint t_rel);
        int n = 0;
        while (cs && n < INIT + 50) begin
            @(negedge clk);
            n++;
        end
        if (cs) begin
            total++;
            bad++;
            $display("FAIL init_timeout act=cs_high exp=cs_low");
        end else begin
            check("cs_fall_time", $time, t_rel + 10 * (INIT + 2));
            check("init_busy", busy, 1);
            check("init_sclk", sclk, 1);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            total++;
            bad++;
            $display("FAIL idle_timeout act=busy exp=idle");
        end
        @(negedge clk);
        check("idle_cs", cs, 1);
        check("idle_sclk", sclk, 0);
    endtask

    task automatic issue(input logic w, input logic [6:0] b,
                         input logic [15:0] a, input logic [3:0] n,
                         input logic exp_busy);
        @(negedge clk);
        CE      = 1'b1;
        write   = w;
        bank    = b;
        addrBus = a;
        nb      = n;
        @(negedge clk);
        CE = 1'b0;
        check("busy_rise", busy, exp_busy);
    endtask

    initial begin
        longint t_rel;
        #1 reset = 1'b1;
        #3;
        check("rst_cs", cs, 1);
        check("rst_bus", bus, 8'hFF);
        check("rst_busy", busy, 1);
        check("rst_dataRead", data_read, 0);
        check("rst_delay", dut.delay_cnt_q, INIT);
        #36 reset = 1'b0;
        push_init();
        init_wait(40);
        wait_idle(100);

        // Write 0xBEEF to {0x01,0x1234}.
        dtw = '0;
        dtw[15:0] = 16'hBEEF;
        vec = '{8'h33, 8'h88, 8'h00, 8'h11, 8'h11, 8'h22, 8'h33,
                8'h44, 8'hEF, 8'hBE};
        push_vec();
        rd_q.push_back(8'h00);
        issue(1'b1, 7'h01, 16'h1234, 4'd2, 1'b1);
        wait_idle(100);

        // Read the same address.
        mdl_read = 1'b1;
        mdl_val  = 8'h5A;
        vec = '{8'hEE, 8'hBB, 8'h00, 8'h11, 8'h11, 8'h22, 8'h33, 8'h44};
        push_vec();
        push_wait_data();
        rd_q.push_back(8'h5A);
        issue(1'b0, 7'h01, 16'h1234, 4'd0, 1'b1);
        wait_idle(100);
        mdl_read = 1'b0;

        // Zero-length write is ignored.
        issue(1'b1, 7'h05, 16'h5555, 4'd0, 1'b0);
        repeat (5) @(negedge clk);
        check("noop_busy", busy, 0);
        check("noop_cs", cs, 1);

        // Top of address space, single byte.
        dtw = '0;
        dtw[7:0] = 8'hA5;
        vec = '{8'h33, 8'h88, 8'h77, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                8'hFF, 8'hA5};
        push_vec();
        rd_q.push_back(8'h5A);
        issue(1'b1, 7'h7F, 16'hFFFF, 4'd1, 1'b1);
        wait_idle(100);

        mdl_read = 1'b1;
        mdl_val  = 8'h3C;
        vec = '{8'hEE, 8'hBB, 8'h77, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        push_vec();
        push_wait_data();
        rd_q.push_back(8'h3C);
        issue(1'b0, 7'h7F, 16'hFFFF, 4'd0, 1'b1);
        wait_idle(100);
        mdl_read = 1'b0;

        // Maximum 15-byte burst at address 0.
        for (int i = 0; i < 15; i++) dtw[8*i +: 8] = 8'(i * 17);
        vec = '{8'h33, 8'h88, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 15; i++) vec.push_back(8'(i * 17));
        push_vec();
        rd_q.push_back(8'h3C);
        issue(1'b1, 7'h00, 16'h0000, 4'd15, 1'b1);
        wait_idle(100);

        // Reset in the middle of the write-data phase.
        push_vec();
        issue(1'b1, 7'h00, 16'h0000, 4'd15, 1'b1);
        repeat (11) @(negedge clk);
        check("abort_cs_low", cs, 0);
        reset = 1'b1;
        #1;
        check("abort_cs", cs, 1);
        check("abort_bus", bus, 8'hFF);
        check("abort_busy", busy, 1);
        check("abort_dataRead", data_read, 0);
        bus_q.delete();
        rd_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        t_rel = $time;
        push_init();
        init_wait(t_rel);
        wait_idle(100);

        mdl_read = 1'b1;
        mdl_val  = 8'h96;
        vec = '{8'hEE, 8'hBB, 8'h00, 8'h11, 8'h11, 8'h22, 8'h33, 8'h44};
        push_vec();
        push_wait_data();
        rd_q.push_back(8'h96);
        issue(1'b0, 7'h01, 16'h1234, 4'd0, 1'b1);
        wait_idle(100);
        mdl_read = 1'b0;

        check("end_bus_q", bus_q.size(), 0);
        check("end_rd_q", rd_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
